pe_nin_mout: RTL



---
 rtl/defines_pkg.sv | 11 +
 rtl/pe_op_alu.sv | 37 +++
 rtl/pe_nin_mout.sv | 62 ++++++
 3 files changed

// File: rtl/defines_pkg.sv
// defines_pkg: shared dataflow fabric types
package defines_pkg;
   typedef enum logic [2:0] {
      OP_OR  = 3'd0,
      OP_AND = 3'd1,
      OP_XOR = 3'd2,
      OP_ADD = 3'd3,
      OP_MAX = 3'd4,
      OP_MIN = 3'd5
   } pe_op_e;
endpackage

// File: rtl/pe_op_alu.sv
// pe_op_alu: combinational reduction of N_IN operands selected by op_mode
module pe_op_alu
   import defines_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int N_IN  = 2
) (
   input  logic [2:0]            op_mode,
   input  logic [N_IN*WIDTH-1:0] data_in,
   output logic [WIDTH-1:0]      result
);
   logic [WIDTH-1:0] r_or, r_and, r_xor, r_add, r_max, r_min, w;
   always_comb begin
      r_or  = '0;
      r_and = '1;
      r_xor = '0;
      r_add = '0;
      r_max = '0;
      r_min = '1;
      w     = '0;
      for (int i = 0; i < N_IN; i++) begin
         w     = data_in[i*WIDTH +: WIDTH];
         r_or  = r_or | w;
         r_and = r_and & w;
         r_xor = r_xor ^ w;
         r_add = r_add + w;
         r_max = w > r_max ? w : r_max;
         r_min = w < r_min ? w : r_min;
      end
   end
   // unused codes 6-7 fall through to OR
   assign result = op_mode == OP_AND ? r_and :
                   op_mode == OP_XOR ? r_xor :
                   op_mode == OP_ADD ? r_add :
                   op_mode == OP_MAX ? r_max :
                   op_mode == OP_MIN ? r_min : r_or;
endmodule

// File: rtl/pe_nin_mout.sv
// pe_nin_mout: N-input join, op ALU, elastic LATENCY-deep pipe, N-output fork
module pe_nin_mout
   import defines_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int N_IN    = 2,
   parameter int N_OUT   = 2,
   parameter int LATENCY = 15
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [N_IN*WIDTH-1:0]          data_in,
   input  logic [2:0]                     op_mode,
   output logic [N_OUT-1:0]               out_valid,
   input  logic [N_OUT-1:0]               out_ready,
   output logic [N_OUT*WIDTH-1:0]         data_out,
   output logic [$clog2(LATENCY+1)-1:0]   occupancy
);
   localparam int OW = $clog2(LATENCY + 1);
   logic [LATENCY-1:0] valid, adv;
   logic [WIDTH-1:0]   data [LATENCY];
   logic [N_OUT-1:0]   done;
   logic [WIDTH-1:0]   alu_result;
   logic               accept, retire, run;
   pe_op_alu #(.WIDTH(WIDTH), .N_IN(N_IN)) u_alu (
      .op_mode (op_mode),
      .data_in (data_in),
      .result  (alu_result)
   );
   assign retire    = valid[LATENCY-1] & (&(done | out_ready));
   assign accept    = in_valid & in_ready;
   assign in_ready  = adv[0];
   assign out_valid = {N_OUT{valid[LATENCY-1]}} & ~done;
   assign data_out  = {N_OUT{data[LATENCY-1]}};
   // a stage may load if any stage from it to the head is empty or the head retires
   always_comb begin
      run = retire;
      adv = '0;
      for (int k = LATENCY - 1; k >= 0; k--) begin
         run    = run | ~valid[k];
         adv[k] = run;
      end
   end
   always_ff @(posedge clk)
      if (rst) begin
         valid     <= '0;
         done      <= '0;
         occupancy <= '0;
         for (int k = 0; k < LATENCY; k++) data[k] <= '0;
      end else begin
         if (adv[0]) valid[0] <= accept;
         if (adv[0] & accept) data[0] <= alu_result;
         for (int k = 1; k < LATENCY; k++) begin
            if (adv[k]) valid[k] <= valid[k-1];
            if (adv[k] & valid[k-1]) data[k] <= data[k-1];
         end
         done      <= retire ? '0 : done | (out_valid & out_ready);
         occupancy <= occupancy + OW'(accept) - OW'(retire);
      end
endmodule
